// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle core: handshaked preload, then run until PC halt,
// watchdog expiry (only when RUN_CTRL_WDT_EN is defined) or clr.
module core_run_ctrl #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned IMEM_DEPTH  = 64,
   parameter int unsigned DMEM_DEPTH  = 32,
   parameter int unsigned RF_DEPTH    = 32,
   parameter int unsigned HALT_REPEAT = 2,
   parameter int unsigned TIMEOUT     = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              clr,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [1:0]        ld_sel,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              imem_we,
   output logic              dmem_we,
   output logic              rf_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              core_rst_n,
   input  logic [ADDR_W-1:0] core_pc,
   output logic [31:0]       cycle_count,
   output logic              done,
   output logic              halted,
   output logic              timed_out,
   output logic              ld_err
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam int unsigned SC_W = (HALT_REPEAT < 2) ? 1 : $clog2(HALT_REPEAT + 1);

   if (HALT_REPEAT < 1 || TIMEOUT < 2) begin : g_param_check
      $error("core_run_ctrl: HALT_REPEAT must be >= 1 and TIMEOUT >= 2");
   end

   logic [2:0]        state_q, state_d;
   logic              imem_we_q, imem_we_d, dmem_we_q, dmem_we_d, rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [31:0]       cycle_count_q, cycle_count_d;
   logic              halted_q, halted_d, timed_out_q, timed_out_d, ld_err_q, ld_err_d;
   logic [ADDR_W-1:0] pc_prev_q, pc_prev_d;
   logic [SC_W-1:0]   same_cnt_q, same_cnt_d;
   logic              first_q, first_d;

   logic              addr_ok, halt_hit, timeout_hit;
   logic [SC_W-1:0]   same_next;
   logic [31:0]       cnt_inc;

`ifdef RUN_CTRL_WDT_EN
   assign cnt_inc     = cycle_count_q + 32'd1;
   assign timeout_hit = (cnt_inc == 32'(TIMEOUT - 1));
`else
   assign cnt_inc     = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 32'd1;
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      addr_ok = 1'b0;
      case (ld_sel)
         2'd0:    addr_ok = (ld_addr < ADDR_W'(IMEM_DEPTH));
         2'd1:    addr_ok = (ld_addr < ADDR_W'(DMEM_DEPTH));
         2'd2:    addr_ok = (ld_addr < ADDR_W'(RF_DEPTH));
         default: addr_ok = 1'b0;
      endcase
   end

   // The first RUN cycle has no valid previous PC, so it never counts as a repeat.
   always_comb begin
      same_next = '0;
      if (!first_q && core_pc == pc_prev_q) same_next = same_cnt_q + SC_W'(1);
   end
   assign halt_hit = (same_next >= SC_W'(HALT_REPEAT));

   always_comb begin
      state_d       = state_q;
      imem_we_d     = 1'b0;
      dmem_we_d     = 1'b0;
      rf_we_d       = 1'b0;
      mem_waddr_d   = mem_waddr_q;
      mem_wdata_d   = mem_wdata_q;
      cycle_count_d = cycle_count_q;
      halted_d      = halted_q;
      timed_out_d   = timed_out_q;
      ld_err_d      = ld_err_q;
      pc_prev_d     = core_pc;
      same_cnt_d    = same_cnt_q;
      first_d       = first_q;
      if (clr) begin
         state_d       = S_IDLE;
         cycle_count_d = '0;
         halted_d      = 1'b0;
         timed_out_d   = 1'b0;
         ld_err_d      = 1'b0;
         same_cnt_d    = '0;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               state_d       = S_LOAD;
               cycle_count_d = '0;
               halted_d      = 1'b0;
               timed_out_d   = 1'b0;
               ld_err_d      = 1'b0;
            end
            S_LOAD: if (ld_valid) begin
               if (addr_ok) begin
                  imem_we_d   = (ld_sel == 2'd0);
                  dmem_we_d   = (ld_sel == 2'd1);
                  rf_we_d     = (ld_sel == 2'd2);
                  mem_waddr_d = ld_addr;
                  mem_wdata_d = ld_data;
               end else begin
                  ld_err_d = 1'b1;
               end
               if (ld_last) state_d = S_SETTLE;
            end
            S_SETTLE: begin
               state_d       = S_RUN;
               cycle_count_d = '0;
               same_cnt_d    = '0;
               first_d       = 1'b1;
            end
            S_RUN: begin
               first_d       = 1'b0;
               same_cnt_d    = same_next;
               cycle_count_d = cnt_inc;
               if (halt_hit || timeout_hit) begin
                  state_d     = S_DONE;
                  halted_d    = halt_hit;
                  timed_out_d = timeout_hit;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         imem_we_q     <= 1'b0;
         dmem_we_q     <= 1'b0;
         rf_we_q       <= 1'b0;
         mem_waddr_q   <= '0;
         mem_wdata_q   <= '0;
         cycle_count_q <= '0;
         halted_q      <= 1'b0;
         timed_out_q   <= 1'b0;
         ld_err_q      <= 1'b0;
         pc_prev_q     <= '0;
         same_cnt_q    <= '0;
         first_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         imem_we_q     <= imem_we_d;
         dmem_we_q     <= dmem_we_d;
         rf_we_q       <= rf_we_d;
         mem_waddr_q   <= mem_waddr_d;
         mem_wdata_q   <= mem_wdata_d;
         cycle_count_q <= cycle_count_d;
         halted_q      <= halted_d;
         timed_out_q   <= timed_out_d;
         ld_err_q      <= ld_err_d;
         pc_prev_q     <= pc_prev_d;
         same_cnt_q    <= same_cnt_d;
         first_q       <= first_d;
      end
   end

   assign ld_ready    = (state_q == S_LOAD);
   assign core_rst_n  = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign imem_we     = imem_we_q;
   assign dmem_we     = dmem_we_q;
   assign rf_we       = rf_we_q;
   assign mem_waddr   = mem_waddr_q;
   assign mem_wdata   = mem_wdata_q;
   assign cycle_count = cycle_count_q;
   assign halted      = halted_q;
   assign timed_out   = timed_out_q;
   assign ld_err      = ld_err_q;
endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl; timeout expectations follow RUN_CTRL_WDT_EN.
module tb_core_run_ctrl;
   logic        clk = 1'b0;
   logic        rst, start, clr, ld_valid, ld_last;
   logic [1:0]  ld_sel;
   logic [31:0] ld_addr, ld_data, core_pc;
   logic        ld_ready, imem_we, dmem_we, rf_we, core_rst_n;
   logic        done, halted, timed_out, ld_err;
   logic [31:0] mem_waddr, mem_wdata, cycle_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   core_run_ctrl #(
      .ADDR_W(32), .DATA_W(32), .IMEM_DEPTH(64), .DMEM_DEPTH(32),
      .RF_DEPTH(32), .HALT_REPEAT(2), .TIMEOUT(40)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .clr(clr),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
      .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
      .imem_we(imem_we), .dmem_we(dmem_we), .rf_we(rf_we),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .core_rst_n(core_rst_n), .core_pc(core_pc),
      .cycle_count(cycle_count), .done(done), .halted(halted),
      .timed_out(timed_out), .ld_err(ld_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] sel, input logic [31:0] addr,
                       input logic [31:0] data, input logic last);
      ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data; ld_last = last;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; clr = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
      ld_sel = 2'd0; ld_addr = '0; ld_data = '0; core_pc = '0;
      tick(); tick();
      check("rst_status", {23'd0, ld_ready, imem_we, dmem_we, rf_we, core_rst_n,
                           done, halted, timed_out, ld_err}, 32'd0);
      check("rst_waddr", mem_waddr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_count", cycle_count, 32'd0);

      // Preload of 4 imem words, then halt on a repeated PC
      rst = 1'b1;
      tick();
      check("idle_ready", {31'd0, ld_ready}, 32'd0);
      do_start();
      check("load_ready", {31'd0, ld_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         beat(2'd0, 32'(i), 32'hC0DE_0000 + 32'(i), i == 3);
         check("imem_we", {29'd0, imem_we, dmem_we, rf_we}, 32'd4);
         check("imem_addr", mem_waddr, 32'(i));
         check("imem_data", mem_wdata, 32'hC0DE_0000 + 32'(i));
      end
      check("settle_ready", {30'd0, ld_ready, core_rst_n}, 32'd0);
      tick();
      check("run_core_rst_n", {31'd0, core_rst_n}, 32'd1);
      check("run_strobe_off", {31'd0, imem_we}, 32'd0);
      check("run_count0", cycle_count, 32'd0);
      for (int k = 0; k < 5; k++) begin
         core_pc = (k < 2) ? 32'(4 * k) : 32'd8;
         if (k == 4) check("halt_not_yet", {31'd0, done}, 32'd0);
         tick();
      end
      check("halt_flags", {28'd0, done, halted, timed_out, core_rst_n}, 32'b1100);
      check("halt_count", cycle_count, 32'd5);
      do_start();
      check("done_ignores_start", {31'd0, done}, 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_done", {28'd0, done, halted, ld_ready, core_rst_n}, 32'd0);
      check("clr_done_count", cycle_count, 32'd0);

      // Rejected beats and clr during RUN
      do_start();
      beat(2'd1, 32'd32, 32'h1111_1111, 1'b0);
      check("dmem_oob_strobe", {29'd0, imem_we, dmem_we, rf_we}, 32'd0);
      check("dmem_oob_err", {31'd0, ld_err}, 32'd1);
      beat(2'd3, 32'd0, 32'h2222_2222, 1'b0);
      check("sel3_strobe", {29'd0, imem_we, dmem_we, rf_we}, 32'd0);
      beat(2'd2, 32'd5, 32'h0000_0055, 1'b1);
      check("rf_we", {29'd0, imem_we, dmem_we, rf_we}, 32'd1);
      check("rf_addr", mem_waddr, 32'd5);
      check("rf_data", mem_wdata, 32'h55);
      tick();
      check("err_run", {30'd0, core_rst_n, ld_err}, 32'b11);
      for (int k = 0; k < 5; k++) begin
         core_pc = 32'(4 * k);
         tick();
      end
      check("run5_count", cycle_count, 32'd5);
      clr = 1'b1;
      core_pc = 32'd20;
      tick();
      clr = 1'b0;
      check("clr_run", {27'd0, core_rst_n, done, halted, timed_out, ld_err}, 32'd0);
      check("clr_run_count", cycle_count, 32'd0);

      // Free-running PC: watchdog expiry or no exit
      do_start();
      beat(2'd0, 32'd63, 32'hDEAD_BEEF, 1'b1);
      check("imem_top_addr", {31'd0, imem_we}, 32'd1);
      tick();
      for (int k = 0; k < 39; k++) begin
         core_pc = 32'(4 * k);
         if (k == 38) check("wdt_not_yet", {31'd0, done}, 32'd0);
         tick();
      end
      check("wdt_count", cycle_count, 32'd39);
`ifdef RUN_CTRL_WDT_EN
      check("wdt_flags", {28'd0, done, halted, timed_out, core_rst_n}, 32'b1010);
`else
      check("nowdt_flags", {28'd0, done, halted, timed_out, core_rst_n}, 32'b0001);
      for (int k = 39; k < 59; k++) begin
         core_pc = 32'(4 * k);
         tick();
      end
      check("nowdt_still_run", {31'd0, done}, 32'd0);
      check("nowdt_count", cycle_count, 32'd59);
`endif
      clr = 1'b1;
      tick();
      clr = 1'b0;

      // Halt coinciding with the watchdog edge
      do_start();
      beat(2'd0, 32'd0, 32'h0, 1'b1);
      tick();
      for (int k = 0; k < 39; k++) begin
         core_pc = (k >= 36) ? 32'd144 : 32'(4 * k);
         tick();
      end
`ifdef RUN_CTRL_WDT_EN
      check("both_flags", {29'd0, done, halted, timed_out}, 32'b111);
`else
      check("both_flags", {29'd0, done, halted, timed_out}, 32'b110);
`endif
      check("both_count", cycle_count, 32'd39);

      // clr beats start in IDLE; reset mid-LOAD drops the in-flight beat
      clr = 1'b1;
      tick();
      start = 1'b1;
      tick();
      clr = 1'b0; start = 1'b0;
      check("clr_over_start", {31'd0, ld_ready}, 32'd0);
      do_start();
      ld_valid = 1'b1; ld_sel = 2'd0; ld_addr = 32'd1; ld_data = 32'h7777_7777;
      rst = 1'b0;
      tick();
      ld_valid = 1'b0;
      check("rst_load_status", {23'd0, ld_ready, imem_we, dmem_we, rf_we, core_rst_n,
                                done, halted, timed_out, ld_err}, 32'd0);
      check("rst_load_waddr", mem_waddr, 32'd0);
      check("rst_load_wdata", mem_wdata, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Synthesizable run controller for the single-cycle RISC-V core. It preloads instruction memory, data memory and the register file over a valid/ready stream while holding the core in reset, then releases the core. It counts run cycles, detects a self-branch halt (PC stuck) and enforces a cycle-budget watchdog, replacing fixed-delay preload/finish sequencing with a parametrised, handshaked block usable on-chip and in benches.

## Interface
- ADDR_W, 32, width of load address and core PC
- DATA_W, 32, load word width
- IMEM_DEPTH, 64, instruction-memory words; higher addresses rejected
- DMEM_DEPTH, 32, data-memory words
- RF_DEPTH, 32, register-file entries
- HALT_REPEAT, 2, consecutive cycles with unchanged PC that declare a halt (>=1)
- TIMEOUT, 40, maximum RUN cycles before watchdog expiry (>=2)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin load; honoured only in IDLE
- clr  in  1  abort/acknowledge; returns to IDLE from any state
- ld_valid  in  1  load beat valid
- ld_ready  out  1  controller accepts beat
- ld_sel  in  2  target: 0 imem, 1 dmem, 2 regfile, 3 illegal
- ld_addr  in  ADDR_W  word index in target
- ld_data  in  DATA_W  word to write
- ld_last  in  1  final beat of preload
- imem_we, dmem_we, rf_we  out  1 each  one-hot write strobes
- mem_waddr  out  ADDR_W  registered write index
- mem_wdata  out  DATA_W  registered write data
- core_rst_n  out  1  core reset, active-low
- core_pc  in  ADDR_W  current core PC
- cycle_count  out  32  RUN cycles elapsed
- done, halted, timed_out, ld_err  out  1 each  status

## Operation
- States: IDLE, LOAD, SETTLE, RUN, DONE.
- IDLE: ld_ready=0, core_rst_n=0. start=1 -> LOAD; status flags and cycle_count cleared on that transition.
- LOAD: ld_ready=1. Each accepted beat (ld_valid & ld_ready) produces exactly one write strobe next cycle. Beat with ld_sel=3 or ld_addr >= depth of target: no strobe, ld_err set (sticky until next start/clr/rst). Accepted beat with ld_last=1 -> SETTLE, even if that beat is rejected.
- SETTLE: one cycle, ld_ready=0; the last write completes here. -> RUN.
- RUN: core_rst_n=1, cycle_count=0 on entry, +1 per RUN cycle. pc_prev captures core_pc each cycle; from the second RUN cycle, same_cnt increments when core_pc==pc_prev, else clears to 0.
- same_cnt reaching HALT_REPEAT -> DONE with halted=1. cycle_count reaching TIMEOUT-1 while still in RUN -> DONE with timed_out=1. Both in the same cycle: both flags set.
- DONE: core_rst_n=0 (core frozen), done=1, flags and cycle_count held. start ignored; clr -> IDLE.
- clr in LOAD/SETTLE/RUN: abort to IDLE next cycle; core_rst_n=0; pending strobe suppressed; flags cleared. clr has priority over every other event, including start in IDLE.

## Timing
- Reset (rst=0 at edge): state IDLE; all outputs 0 (ld_ready, strobes, mem_waddr, mem_wdata, core_rst_n, cycle_count, done, halted, timed_out, ld_err). Reset mid-LOAD or mid-RUN behaves identically; no in-flight write is issued.
- Beat accepted at edge N -> strobe high and mem_waddr/mem_wdata valid for cycle N+1 only; back-to-back beats give back-to-back strobes.
- ld_last accepted at edge N: SETTLE in N+1, RUN in N+2 (core_rst_n rises at N+2).
- Halt latency: DONE the cycle after same_cnt reaches HALT_REPEAT; core_rst_n falls with done.

## Configuration
- RUN_CTRL_WDT_EN defined: TIMEOUT watchdog active as above.
- Undefined: watchdog logic removed; timed_out tied 0; RUN exits only on halt or clr; cycle_count still counts, saturating at 0xFFFFFFFF.

## Test plan
- Reset, start, 4 imem beats (addr 0..3, last on 3) -> 4 imem_we pulses with matching addr/data; core_rst_n rises 2 cycles after last beat.
- Core PC sequence 0,4,8,8,8 -> halted=1, done=1, timed_out=0, core_rst_n=0 one cycle after second repeat.
- PC increments forever, TIMEOUT=40 -> timed_out=1, cycle_count=39, halted=0 (macro defined); macro undefined -> no exit.
- dmem beat addr 32 (DMEM_DEPTH=32) and ld_sel=3 beat -> no strobes, ld_err=1; load still completes on ld_last.
- clr asserted during RUN cycle 5 -> IDLE next cycle, core_rst_n=0, flags 0; rst=0 mid-LOAD -> all outputs 0, no write.
- Halt and timeout in same cycle (TIMEOUT tuned) -> halted=1 and timed_out=1 together.
